// File: rtl/reg_pipeline.sv
// Elastic register pipeline: DEPTH valid/ready stages with bubble collapse,
// synchronous flush and a registered occupancy count.
module reg_pipeline #(
  parameter int                 WIDTH       = 5,
  parameter int                 DEPTH       = 2,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  input  logic                           flush,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] data_q  [DEPTH];
  logic [WIDTH-1:0] up_data [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [DEPTH-1:0] up_valid;
  logic [DEPTH-1:0] load;
  logic [DEPTH:0]   ready;
  logic [OCC_W-1:0] count_d;
  logic             ready_acc;

  // ready chain is built with a scalar accumulator so the vector never feeds itself
  always_comb begin
    ready     = '0;
    ready_acc = out_ready;
    ready[DEPTH] = out_ready;
    for (int i = DEPTH-1; i >= 0; i--) begin
      ready_acc = !valid_q[i] || ready_acc;
      ready[i]  = ready_acc;
    end

    up_valid   = '0;
    up_data[0] = in_data;
    up_valid[0] = in_valid;
    for (int i = 1; i < DEPTH; i++) begin
      up_valid[i] = valid_q[i-1];
      up_data[i]  = data_q[i-1];
    end

    load    = '0;
    valid_d = '0;
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      load[i]    = up_valid[i] && ready[i] && !flush;
      valid_d[i] = !flush && (load[i] || (valid_q[i] && !ready[i+1]));
      count_d    = count_d + OCC_W'(valid_d[i]);
    end
  end

  // flush suppresses every load, so data registers keep their contents
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VALUE;
      end
    end else begin
      valid_q   <= valid_d;
      occupancy <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (load[i]) begin
          data_q[i] <= up_data[i];
        end
      end
    end
  end

  assign in_ready  = ready[0] && !flush;
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: tb/tb_reg_pipeline.sv
// Randomized and directed bench for reg_pipeline against a slot-movement model
// plus an in-order scoreboard; a second DEPTH=1 instance checks alternating stalls.
module tb_reg_pipeline;

  localparam int              WIDTH   = 5;
  localparam int              DEPTH   = 3;
  localparam logic [WIDTH-1:0] RST_VAL = 5'h1F;

  logic             clk;
  logic             reset;
  logic             in_valid, in_ready, out_valid, out_ready, flush;
  logic [WIDTH-1:0] in_data, out_data;
  logic [1:0]       occupancy;

  logic             d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready;
  logic [WIDTH-1:0] d1_in_data, d1_out_data;
  logic [0:0]       d1_occupancy;

  int checks = 0;
  int errors = 0;

  logic             m_valid [DEPTH];
  logic [WIDTH-1:0] m_data  [DEPTH];
  logic [WIDTH-1:0] sb [$];
  logic             m1_valid;
  logic [WIDTH-1:0] sb1 [$];

  reg_pipeline #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VALUE(RST_VAL)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .occupancy(occupancy)
  );

  reg_pipeline #(.WIDTH(WIDTH), .DEPTH(1), .RESET_VALUE(RST_VAL)) u_dut1 (
    .clk(clk), .reset(reset),
    .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_data(d1_in_data),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_data(d1_out_data),
    .flush(1'b0), .occupancy(d1_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_data[i]  = RST_VAL;
    end
    sb.delete();
    m1_valid = 1'b0;
    sb1.delete();
  endtask

  task automatic checkState();
    int occ;
    occ = 0;
    for (int i = 0; i < DEPTH; i++) occ += int'(m_valid[i]);
    checkOutput("out_valid", 64'(out_valid), 64'(m_valid[DEPTH-1]));
    checkOutput("out_data", 64'(out_data), 64'(m_data[DEPTH-1]));
    checkOutput("occupancy", 64'(occupancy), 64'(occ));
  endtask

  // One cycle: words advance one slot when the slot ahead ends up free;
  // the last slot empties only when downstream takes it.
  task automatic applyStimulus(input logic iv, input logic [WIDTH-1:0] id,
                               input logic ordy, input logic fl);
    logic             nv [DEPTH];
    logic [WIDTH-1:0] nd [DEPTH];
    logic             exp_ready;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      nv[i] = 1'b0;
      nd[i] = m_data[i];
    end
    if (!fl) begin
      for (int p = DEPTH-1; p >= 0; p--) begin
        if (m_valid[p]) begin
          if (p == DEPTH-1) begin
            if (ordy) begin
              checkOutput("sb_nonempty", 64'(sb.size() > 0), 64'd1);
              if (sb.size() > 0) checkOutput("order", 64'(out_data), 64'(sb.pop_front()));
            end else begin
              nv[p] = 1'b1;
            end
          end else if (!nv[p+1]) begin
            nv[p+1] = 1'b1;
            nd[p+1] = m_data[p];
          end else begin
            nv[p] = 1'b1;
          end
        end
      end
    end
    exp_ready = !nv[0] && !fl;
    checkOutput("in_ready", 64'(in_ready), 64'(exp_ready));
    if (fl) begin
      sb.delete();
    end else if (iv && exp_ready) begin
      nv[0] = 1'b1;
      nd[0] = id;
      sb.push_back(id);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = nv[i];
      m_data[i]  = nd[i];
    end
    checkState();
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    d1_in_valid = 1'b0; d1_in_data = '0; d1_out_ready = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkState();
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);

    // back-to-back with out_ready high: one word per cycle after DEPTH edges
    for (int i = 1; i <= 6; i++) applyStimulus(1'b1, WIDTH'(i), 1'b1, 1'b0);
    checkOutput("steady_occ", 64'(occupancy), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // fill while stalled, then release with the blocked word still offered
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b1, WIDTH'(5'h08 + i), 1'b0, 1'b0);
    checkOutput("full_occ", 64'(occupancy), 64'(DEPTH));
    checkOutput("full_data", 64'(out_data), 64'h08);
    applyStimulus(1'b1, 5'h0B, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // bubble collapse behind a stalled head word
    applyStimulus(1'b1, 5'h11, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1'b1, WIDTH'(5'h12 + i), 1'b0, 1'b0);
    checkOutput("bubble_occ", 64'(occupancy), 64'(DEPTH));

    // flush with in_valid high discards everything and captures nothing
    applyStimulus(1'b1, 5'h1A, 1'b0, 1'b1);
    checkOutput("flush_occ", 64'(occupancy), 64'd0);
    checkOutput("flush_valid", 64'(out_valid), 64'd0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // async reset between edges with two words held
    applyStimulus(1'b1, 5'h03, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'h04, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("arst_valid", 64'(out_valid), 64'd0);
    checkOutput("arst_data", 64'(out_data), 64'(RST_VAL));
    checkOutput("arst_occ", 64'(occupancy), 64'd0);
    #1;
    reset = 1'b0;
    modelReset();

    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'b1 && ($urandom_range(0, 9) < 7), WIDTH'($urandom),
                    $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;

    // DEPTH=1 with continuous input and alternating out_ready
    for (int n = 0; n < 40; n++) begin
      logic exp_ready;
      d1_in_valid  = 1'b1;
      d1_in_data   = WIDTH'(n + 1);
      d1_out_ready = n[0];
      #1;
      exp_ready = !m1_valid || d1_out_ready;
      checkOutput("d1_in_ready", 64'(d1_in_ready), 64'(exp_ready));
      checkOutput("d1_out_valid", 64'(d1_out_valid), 64'(m1_valid));
      if (m1_valid && d1_out_ready) begin
        checkOutput("d1_sb_nonempty", 64'(sb1.size() > 0), 64'd1);
        if (sb1.size() > 0) checkOutput("d1_order", 64'(d1_out_data), 64'(sb1.pop_front()));
        m1_valid = 1'b0;
      end
      if (exp_ready) begin
        sb1.push_back(d1_in_data);
        m1_valid = 1'b1;
      end
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_pipeline.md
REG_PIPELINE -- requirements
Module: reg_pipeline

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, meaning the data word width in bits (legal range 1 to 64).
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning the number of register stages (legal range 1 to 16).
REQ-003 The block SHALL have parameter RESET_VALUE, default 0, a WIDTH-bit value meaning the content of every data stage after reset.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, an asynchronous active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1, meaning the upstream word is valid.
REQ-007 The block SHALL have port in_ready, output, 1, meaning stage 0 accepts a word this cycle.
REQ-008 The block SHALL have port in_data, input, WIDTH, meaning the upstream word.
REQ-009 The block SHALL have port out_valid, output, 1, meaning the last stage holds a valid word.
REQ-010 The block SHALL have port out_ready, input, 1, meaning downstream accepts the word this cycle.
REQ-011 The block SHALL have port out_data, output, WIDTH, meaning the contents of the last stage.
REQ-012 The block SHALL have port flush, input, 1, a synchronous request to discard all held words.
REQ-013 The block SHALL have port occupancy, output, clog2(DEPTH+1) bits, meaning the count of valid stages.

Function
REQ-014 Each stage i SHALL hold a data register and a valid bit; out_data/out_valid SHALL be driven directly from stage DEPTH-1 registers.
REQ-015 Stage ready SHALL be ready_i = !valid_i || ready_(i+1), with ready_DEPTH = out_ready; in_ready = ready_0 && !flush (combinational path from out_ready permitted).
REQ-016 A transfer into stage i SHALL occur when its upstream valid and ready_i are both 1; stage i then loads the upstream data and sets valid_i.
REQ-017 A stage whose word moves downstream with no incoming word SHALL clear its valid bit and SHALL retain its data register value.
REQ-018 Bubbles SHALL collapse: an empty stage SHALL accept a word even when downstream is stalled.
REQ-019 Minimum latency SHALL be DEPTH cycles: a word accepted at edge N SHALL appear on out_data with out_valid=1 after edge N+DEPTH-1 when no stall occurs.
REQ-020 Throughput SHALL be one word per cycle when out_ready is held 1.
REQ-021 While out_valid=1 and out_ready=0, out_data SHALL remain stable until the transfer completes.
REQ-022 Word order SHALL be preserved; no word SHALL be duplicated or dropped except by flush or reset.
REQ-023 Full boundary: with all stages valid and out_ready=0, in_ready SHALL be 0; with out_ready=1, the block SHALL accept and emit in the same cycle and occupancy SHALL stay DEPTH.
REQ-024 Empty boundary: with occupancy=0, out_valid SHALL be 0 and in_ready SHALL be 1 unless flush=1.
REQ-025 Flush SHALL clear every valid bit at the next rising edge, ignoring in_valid that cycle, and SHALL have priority over all transfers; data registers SHALL be unchanged by flush.
REQ-026 occupancy SHALL be a registered popcount of valid bits, exact on every cycle, never exceeding DEPTH.

Reset
REQ-027 Asserting reset SHALL immediately, without a clock edge, clear all valid bits, load RESET_VALUE into every data stage, and force occupancy=0, out_valid=0.
REQ-028 Reset asserted mid-transfer SHALL discard all words in flight; normal operation SHALL resume at the first rising edge after reset deasserts.

Verification
REQ-029 WIDTH=5, DEPTH=2, out_ready=1, send 5'h01..5'h05 back-to-back -> outputs 01..05 on consecutive cycles, first at edge N+1 after acceptance, occupancy steady at 2.
REQ-030 DEPTH=3, out_ready=0, send 4 words -> first 3 accepted, in_ready=0 on the 4th, occupancy=3, out_data stable at word 1; raise out_ready -> word 4 accepted that same cycle.
REQ-031 DEPTH=4, one word in stage 3 stalled, stages 0-2 empty -> next 3 words accepted on consecutive cycles (bubble collapse), occupancy reaches 4.
REQ-032 Occupancy=3, flush=1 with in_valid=1 -> after edge occupancy=0, out_valid=0, incoming word not captured.
REQ-033 RESET_VALUE=5'h1F, occupancy=2, reset pulsed between clock edges -> out_valid=0, out_data=5'h1F, occupancy=0 before the next edge.
REQ-034 DEPTH=1, alternate out_ready 1/0 with continuous input -> no loss or duplication, order preserved, in_ready tracks !out_valid || out_ready.
